// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared encodings for the shift sequence controller.
//   op_e    - command operations presented on cmd_op
//   mode_e  - universal shift register core modes
//   state_e - controller FSM states
//   op_to_mode() - core mode that implements one step of a command op
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,  // serial load via shift right
    OP_ROR  = 2'b01,  // rotate right N times
    OP_SHL  = 2'b10,  // shift left N times, zero fill
    OP_DUMP = 2'b11   // serial dump MSB first via shift left
  } op_e;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,  // sIn enters Q[WIDTH-1]
    MODE_SHL  = 2'b10,  // zero enters Q[0]
    MODE_ROR  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic mode_e op_to_mode(input op_e op);
    mode_e m;
    case (op)
      OP_LOAD: m = MODE_SHR;
      OP_ROR:  m = MODE_ROR;
      OP_SHL:  m = MODE_SHL;
      OP_DUMP: m = MODE_SHL;
      default: m = MODE_HOLD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_core.sv
// shift_reg_core: WIDTH-bit universal shift register.
// Ports:
//   clk  - clock, rising edge
//   Re   - asynchronous active-low reset, clears Q
//   mode - 00 hold, 01 shift right (sIn -> MSB), 10 shift left (0 -> LSB),
//          11 rotate right
//   sIn  - serial input for shift right
//   Q    - register contents
module shift_reg_core
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             Re,
  input  logic [1:0]       mode,
  input  logic             sIn,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    case (mode_e'(mode))
      MODE_HOLD: q_d = q_q;
      MODE_SHR:  q_d = {sIn, q_q[WIDTH-1:1]};
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], 1'b0};
      MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge Re) begin
    if (!Re) q_q <= '0;
    else     q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command-driven sequencer around a universal shift register.
// Accepts one command in IDLE, performs N single-bit steps in RUN (one per
// cycle), pulses done for one cycle in DONE, then returns to IDLE.
// Ports:
//   clk, Re              - clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready  - command handshake, accepted only in IDLE
//   cmd_op               - 00 serial load, 01 rotate right, 10 shift left,
//                          11 serial dump
//   cmd_cnt              - step count for ops 01/10, 0 means WIDTH
//   sIn / sOut           - serial in (op 00) / serial out (op 11, MSB first)
//   Q                    - register contents
//   busy / done          - RUN indicator / one-cycle completion pulse
//   abort                - only with SHIFT_SEQ_ABORT_EN defined: ends RUN at
//                          the next edge without shifting
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     Re,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [$clog2(WIDTH)-1:0] cmd_cnt,
  input  logic                     sIn,
  output logic                     sOut,
  output logic [WIDTH-1:0]         Q,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic                     abort,
`endif
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  // One extra bit so the counter can hold WIDTH itself.
  localparam int unsigned CW    = CNT_W + 1;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mode_e         mode;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    mode      = MODE_HOLD;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    sOut      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          state_d = ST_RUN;
          if (op_e'(cmd_op) == OP_LOAD || op_e'(cmd_op) == OP_DUMP ||
              cmd_cnt == '0)
            cnt_d = CW'(WIDTH);
          else
            cnt_d = {1'b0, cmd_cnt};
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (op_q == OP_DUMP) sOut = Q[WIDTH-1];
`ifdef SHIFT_SEQ_ABORT_EN
        if (abort) begin
          state_d = ST_DONE;
        end else
`endif
        begin
          mode  = op_to_mode(op_q);
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  shift_reg_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .Re   (Re),
    .mode (mode),
    .sIn  (sIn),
    .Q    (Q)
  );

endmodule
